des_key_sched: RTL and testbench
================================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by DES.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock shared with the round pipeline.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  request to begin a 16-subkey sequence; sampled only in IDLE.
REQ-006 key_in  in  64  DES key; DES bit 1 = key_in[63]; parity bits 8,16,...,64 are ignored.
REQ-007 decrypt  in  1  sampled with start: 0 = emit K1..K16; 1 = emit K16..K1.
REQ-008 subkey_ready  in  1  downstream accepts the current subkey.
REQ-009 subkey  out  48  current subkey, PC-2 output; DES bit 1 = subkey[47].
REQ-010 subkey_idx  out  4  round number minus 1 of the subkey presented (0 = K1 ... 15 = K16).
REQ-011 subkey_valid  out  1  subkey and subkey_idx are valid.
REQ-012 busy  out  1  high in all states except IDLE.
REQ-013 done  out  1  one-cycle pulse after the 16th subkey is accepted.

Function
REQ-014 The block SHALL implement states IDLE, RUN and FIN.
REQ-015 IDLE with start=1: latch PC-1(key_in) into C (28 bits) and D (28 bits), latch decrypt, clear the count, and go to RUN.
REQ-016 Encrypt: the first subkey presented SHALL be PC-2(rotl(C0D0, 1)).
REQ-017 Encrypt: before each later subkey, C and D SHALL each rotate left by 1 for rounds 1, 2, 9 and 16, and by 2 for all other rounds.
REQ-018 Decrypt: the first subkey SHALL be PC-2(C0D0), which is K16.
REQ-019 Decrypt: after each handshake, C and D SHALL rotate right by 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1 for the 2nd through 16th subkeys.
REQ-020 In RUN, subkey_valid SHALL be 1; it SHALL be asserted in the cycle after the start cycle.
REQ-021 A handshake occurs when subkey_valid=1 and subkey_ready=1 in the same cycle.
REQ-022 On each handshake the block SHALL advance to the next subkey, so the next subkey appears in the following cycle (one subkey per cycle under constant ready).
REQ-023 While subkey_ready=0, subkey, subkey_idx and the internal C/D/count SHALL hold stable.
REQ-024 subkey_idx SHALL be count when encrypting and 15 - count when decrypting.
REQ-025 On the 16th handshake the block SHALL go to FIN, and subkey_valid SHALL drop in the next cycle.
REQ-026 FIN lasts exactly one cycle with done=1, then returns to IDLE.
REQ-027 start outside IDLE, including in FIN, SHALL be ignored; key_in and decrypt SHALL be ignored outside the start cycle.
REQ-028 start asserted in the cycle after FIN SHALL be accepted normally.
REQ-029 The subkey output SHALL be registered or derived only from registered C/D, with no combinational path from key_in to subkey.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, subkey=0, subkey_idx=0, subkey_valid=0, busy=0, done=0, and C=D=count=0.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence with no further subkeys or done.
REQ-032 After rst_n deasserts, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 Encrypt streaming: key_in=0x133457799BBCDFF1, decrypt=0, start for 1 cycle, ready=1 -> next cycle subkey=0x1B02EFFC7072 idx=0; then subkey=0x79AED9DBC9E5 idx=1; 16th subkey=0xCB3D8B0E17F5 idx=15; done exactly 1 cycle after it; busy low after that.
REQ-034 Decrypt: same key with decrypt=1 -> first subkey=0xCB3D8B0E17F5 idx=15, last subkey=0x1B02EFFC7072 idx=0; all 16 are the encrypt sequence reversed.
REQ-035 Backpressure: random subkey_ready during encrypt -> exactly 16 handshakes in order idx 0..15 with values matching REQ-033; outputs stable while ready=0.
REQ-036 Start while busy: pulse start with a different key at idx=5 -> sequence unchanged; start on the cycle after FIN -> new sequence begins.
REQ-037 Reset mid-run: assert rst_n=0 at idx=7 -> all outputs 0 asynchronously; no done; a subsequent start restarts at idx=0 with the correct K1.
REQ-038 Parity independence: key_in=0x133457799BBCDFF1 with every parity bit flipped (XOR 0x0101010101010101) -> subkey sequence identical to REQ-033.

Source files
------------

// File: rtl/des_key_sched.sv
// DES key schedule: expands a 64-bit key into the 16 round subkeys, one per
// accepted handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_idx,
  output logic        subkey_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Tables use DES bit numbering: bit 1 is the MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    logic [5:0]  pos;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      pos = 6'(64 - PC1_TAB[i]);
      r[6'(55 - i)] = k[pos];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    logic [5:0]  pos;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      pos = 6'(56 - PC2_TAB[i]);
      r[6'(47 - i)] = cd[pos];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  state_t      state;
  logic [27:0] c, d;
  logic [3:0]  count;
  logic        dec;

  logic        shift_one;
  logic [27:0] c_l, d_l, c_r, d_r;
  logic        unused_parity;

  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  // Encrypt keeps C(r-1)D(r-1) while presenting Kr, so the round's left shift
  // is applied on the way to PC-2; decrypt keeps the presented CD directly.
  always_comb begin
    if (dec)
      shift_one = (count == 4'd0) || (count == 4'd7) || (count == 4'd14);
    else
      shift_one = (count == 4'd0) || (count == 4'd1) || (count == 4'd8) || (count == 4'd15);
    c_l = rotl(c, shift_one);
    d_l = rotl(d, shift_one);
    c_r = rotr(c, shift_one);
    d_r = rotr(d, shift_one);
  end

  assign subkey     = dec ? pc2({c, d}) : pc2({c_l, d_l});
  assign subkey_idx = dec ? (4'd15 - count) : count;

  // NOTE: every register here, including C/D, is reset so that the outputs
  // derived from them read as zero immediately on rst_n falling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      c            <= '0;
      d            <= '0;
      count        <= '0;
      dec          <= 1'b0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            {c, d}       <= pc1(key_in);
            dec          <= decrypt;
            count        <= '0;
            state        <= RUN;
            subkey_valid <= 1'b1;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          if (subkey_ready) begin
            c     <= dec ? c_r : c_l;
            d     <= dec ? d_r : d_l;
            count <= count + 4'd1;
            if (count == 4'd15) begin
              state        <= FIN;
              subkey_valid <= 1'b0;
              done         <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          subkey_valid <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: stimulus pushes expected subkeys,
// a negedge monitor compares whatever the DUT presents.
module tb_des_key_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key_in = '0;
  logic        decrypt = 1'b0;
  logic        subkey_ready = 1'b1;
  logic [47:0] subkey;
  logic [3:0]  subkey_idx;
  logic        subkey_valid;
  logic        busy;
  logic        done;

  des_key_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .decrypt(decrypt), .subkey_ready(subkey_ready), .subkey(subkey),
    .subkey_idx(subkey_idx), .subkey_valid(subkey_valid), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  // Published K1..K16 for the classic example key.
  logic [47:0] ks [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  typedef struct {
    logic [47:0] key;
    logic [3:0]  idx;
    bit          last;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   done_seen = 0;
  bit   done_pend = 1'b0;
  bit   rand_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_seq(input logic dec);
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.idx  = dec ? 4'(15 - i) : 4'(i);
      e.key  = ks[e.idx];
      e.last = (i == 15);
      q.push_back(e);
    end
  endtask

  // Monitor: compares the presented subkey against the queue head every cycle
  // it is valid (so stalls are checked too) and pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      done_pend = 1'b0;
    end else begin
      check("done_timing", done, done_pend);
      if (done) done_seen++;
      done_pend = 1'b0;
      if (subkey_valid) begin
        if (q.size() == 0) begin
          check("unexpected_subkey", subkey_valid, 1'b0);
        end else begin
          check("subkey", subkey, q[0].key);
          check("subkey_idx", subkey_idx, q[0].idx);
          if (subkey_ready) begin
            done_pend = q[0].last;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      subkey_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] k, input logic dec);
    push_seq(dec);
    key_in  = k;
    decrypt = dec;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    key_in  = ~k;
    decrypt = ~dec;
    check("valid_after_start", subkey_valid, 1'b1);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    check("done_reached", done, 1'b1);
    check("busy_in_fin", busy, 1'b1);
    check("all_subkeys_seen", 64'(q.size()), 64'd0);
  endtask

  task automatic wait_idx(input logic [3:0] target);
    int n;
    n = 0;
    while (!(subkey_valid && subkey_idx == target) && n < 100) begin
      tick();
      n++;
    end
    check("reached_idx", subkey_idx, target);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, subkey_valid, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_subkey", subkey, 48'h0);
    check("rst_idx", subkey_idx, 4'h0);
    check("rst_valid", subkey_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
  endtask

  initial begin
    int cyc;
    int done_before;

    #1 rst_n = 1'b0;
    #2 check_reset_outputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Encrypt, streaming: one subkey per cycle.
    do_start(KEY, 1'b0);
    wait_done(cyc);
    check("stream_cycles", 64'(cyc), 64'd16);
    tick();
    check_idle("enc_end");

    // Decrypt: reversed order.
    do_start(KEY, 1'b1);
    wait_done(cyc);
    check("dec_stream_cycles", 64'(cyc), 64'd16);
    tick();
    check_idle("dec_end");

    // Random backpressure.
    rand_mode = 1'b1;
    do_start(KEY, 1'b0);
    wait_done(cyc);
    rand_mode = 1'b0;
    tick();
    subkey_ready = 1'b1;
    check_idle("bp_end");

    // Parity bits ignored.
    do_start(KEY ^ 64'h0101010101010101, 1'b0);
    wait_done(cyc);
    tick();
    check_idle("parity_end");

    // Start while busy is ignored; start held over FIN takes effect in IDLE.
    do_start(KEY, 1'b0);
    wait_idx(4'd5);
    key_in  = 64'hFEDCBA9876543210;
    decrypt = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_done(cyc);
    push_seq(1'b1);
    key_in  = KEY;
    decrypt = 1'b1;
    start   = 1'b1;
    tick();
    check("fin_start_ignored", subkey_valid, 1'b0);
    tick();
    start   = 1'b0;
    check("restart_valid", subkey_valid, 1'b1);
    check("restart_idx", subkey_idx, 4'd15);
    wait_done(cyc);
    tick();
    check_idle("restart_end");

    // Asynchronous reset mid-sequence.
    done_before = done_seen;
    do_start(KEY, 1'b0);
    wait_idx(4'd7);
    #2 rst_n = 1'b0;
    q.delete();
    #1 check_reset_outputs();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_idle("abort_idle");
    check("abort_no_done", 64'(done_seen), 64'(done_before));
    do_start(KEY, 1'b0);
    wait_done(cyc);
    tick();
    check_idle("after_abort_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
